// File: rtl/k_and_s_control_unit_if.sv
// Decoded-instruction type shared by the K&S data path and control unit, plus the
// control-unit <-> data-path signal bundle.
package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP, I_HALT, I_ADD, I_SUB, I_AND, I_OR, I_MOVE, I_LOAD,
    I_STORE, I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV
  } decoded_instruction_type;
endpackage

interface k_and_s_control_unit_if;
  import k_and_s_pkg::*;

  decoded_instruction_type decoded_instruction;
  logic                    zero_op;
  logic                    neg_op;
  logic                    unsigned_overflow;
  logic                    signed_overflow;

  logic                    branch;
  logic                    pc_enable;
  logic                    ir_enable;
  logic                    addr_sel;
  logic                    c_sel;
  logic [1:0]              operation;
  logic                    write_reg_enable;
  logic                    flags_reg_enable;
  logic                    ram_write_enable;

  modport master (
    input  decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
    output branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
           write_reg_enable, flags_reg_enable, ram_write_enable
  );

  modport slave (
    output decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
    input  branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
           write_reg_enable, flags_reg_enable, ram_write_enable
  );
endinterface

// File: rtl/k_and_s_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the K&S processor, with a
// configurable RAM read latency and a retired-instruction counter.
module k_and_s_control_unit #(
  parameter int RAM_WAIT_CYCLES = 1,
  parameter int CNT_W           = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  k_and_s_control_unit_if.master    ctrl,
  output logic                      halted,
  output logic [CNT_W-1:0]          instr_count
);
  import k_and_s_pkg::*;

  typedef enum logic [3:0] {
    FETCH, FETCH_LATCH, DECODE, EXEC_ALU, EXEC_MOVE,
    LOAD_WAIT, LOAD_WB, EXEC_STORE, EXEC_BR, HALT
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(RAM_WAIT_CYCLES - 1);

  state_t     state;
  state_t     next_state;
  logic [3:0] wait_cnt;
  logic       take;
  logic       retire;
  logic       unused_signed_overflow;

  // The signed flag is part of the data-path bundle but no branch tests it.
  assign unused_signed_overflow = ctrl.signed_overflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      wait_cnt    <= '0;
      instr_count <= '0;
    end else begin
      state <= next_state;
      if ((state == FETCH || state == LOAD_WAIT) && next_state == state)
        wait_cnt <= wait_cnt + 4'd1;
      else
        wait_cnt <= '0;
      if (retire)
        instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH:       if (wait_cnt == WAIT_LAST) next_state = FETCH_LATCH;
      FETCH_LATCH: next_state = DECODE;
      DECODE: begin
        case (ctrl.decoded_instruction)
          I_ADD, I_SUB, I_AND, I_OR:       next_state = EXEC_ALU;
          I_MOVE:                          next_state = EXEC_MOVE;
          I_LOAD:                          next_state = LOAD_WAIT;
          I_STORE:                         next_state = EXEC_STORE;
          I_BRANCH, I_BZERO, I_BNZERO, I_BNEG,
          I_BNNEG, I_BOV, I_BNOV:          next_state = EXEC_BR;
          I_HALT:                          next_state = HALT;
          default:                         next_state = FETCH;
        endcase
      end
      LOAD_WAIT:   if (wait_cnt == WAIT_LAST) next_state = LOAD_WB;
      EXEC_ALU, EXEC_MOVE, LOAD_WB,
      EXEC_STORE, EXEC_BR:                 next_state = FETCH;
      HALT:        next_state = HALT;
      default:     next_state = FETCH;
    endcase
    // An instruction retires when it hands back to FETCH; HALT retires on entry.
    retire = (next_state == FETCH && state != FETCH) ||
             (next_state == HALT && state != HALT);
  end

  always_comb begin
    take = 1'b0;
    case (ctrl.decoded_instruction)
      I_BRANCH: take = 1'b1;
      I_BZERO:  take = ctrl.zero_op;
      I_BNZERO: take = !ctrl.zero_op;
      I_BNEG:   take = ctrl.neg_op;
      I_BNNEG:  take = !ctrl.neg_op;
      I_BOV:    take = ctrl.unsigned_overflow;
      I_BNOV:   take = !ctrl.unsigned_overflow;
      default:  take = 1'b0;
    endcase
  end

  // Outputs are forced idle during reset so an aborted store never writes.
  always_comb begin
    ctrl.branch           = 1'b0;
    ctrl.pc_enable        = 1'b0;
    ctrl.ir_enable        = 1'b0;
    ctrl.addr_sel         = 1'b0;
    ctrl.c_sel            = 1'b0;
    ctrl.operation        = 2'b00;
    ctrl.write_reg_enable = 1'b0;
    ctrl.flags_reg_enable = 1'b0;
    ctrl.ram_write_enable = 1'b0;
    halted                = 1'b0;
    if (!rst) begin
      case (state)
        FETCH_LATCH: begin
          ctrl.ir_enable = 1'b1;
          ctrl.pc_enable = 1'b1;
        end
        EXEC_ALU: begin
          case (ctrl.decoded_instruction)
            I_SUB:   ctrl.operation = 2'b01;
            I_AND:   ctrl.operation = 2'b10;
            I_OR:    ctrl.operation = 2'b11;
            default: ctrl.operation = 2'b00;
          endcase
          ctrl.write_reg_enable = 1'b1;
          ctrl.flags_reg_enable = 1'b1;
        end
        EXEC_MOVE: begin
          ctrl.operation        = 2'b11;
          ctrl.write_reg_enable = 1'b1;
        end
        LOAD_WAIT: ctrl.addr_sel = 1'b1;
        LOAD_WB: begin
          ctrl.addr_sel         = 1'b1;
          ctrl.c_sel            = 1'b1;
          ctrl.write_reg_enable = 1'b1;
        end
        EXEC_STORE: begin
          ctrl.addr_sel         = 1'b1;
          ctrl.ram_write_enable = 1'b1;
        end
        EXEC_BR: begin
          ctrl.pc_enable = take;
          ctrl.branch    = take;
        end
        HALT:    halted = 1'b1;
        default: ;
      endcase
    end
  end
endmodule
